secuenciador_alu: RTL and testbench
===================================

# secuenciador_alu

Operation sequencer that sits directly upstream of the ALU operation units (complemento and its siblings). It latches an opcode and two 4-bit operands, packs them onto the shared unit data bus, and raises the selected unit's `enable`. It then waits for that unit's `done` and captures its result. Finally it drops `enable`, waits for `done` to clear, and reports a single-cycle completion pulse with result and error status to the host.

## Interface
Parameters:
- `INPUTSIZE`, 8, width of unit data bus and results; must be even, upper half = operand A, lower half = operand B
- `N_OPS`, 4, number of attached operation units (one enable/done pair each)
- `TIMEOUT`, 15, cycles allowed per wait state before abort

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous and active-high
- `start` in 1: request, sampled only in IDLE
- `opcode` in 2: unit select, 0 = complemento
- `operando_a` in INPUTSIZE/2: operand A
- `operando_b` in INPUTSIZE/2: operand B
- `data` out INPUTSIZE: packed `{A,B}` to all units, registered
- `enable` out N_OPS: one-hot unit enable, registered
- `done_op` in N_OPS: per-unit done, asynchronous to `clk`
- `result_op` in N_OPS*INPUTSIZE: flattened unit results, unit i at bits [i*INPUTSIZE +: INPUTSIZE]
- `result` out INPUTSIZE: captured result
- `done` out 1: one-cycle completion pulse
- `error` out 1: status of the last operation, valid from `done` until next start
- `busy` out 1: high whenever state is not IDLE

## Operation
- Reset: state IDLE. `data`, `enable`, `result`, `done`, `error`, `busy`, timeout counter and synchronizers all 0.
- States: IDLE, CARGA, ESPERA, LIBERA, FIN.
- **IDLE**
  - `start`=1 latches opcode and operands, clears `error`, goes to CARGA.
  - `start` in any other state is ignored; no queuing.
- **CARGA**
  - `data` <= `{operando_a, operando_b}` (latched copies).
  - If opcode >= N_OPS: `error`<=1, `result`<=0, go to FIN; no enable is raised.
  - Otherwise `enable[opcode]`<=1, counter cleared, go to ESPERA. `data` is therefore stable one cycle before the enable edge.
- **ESPERA**
  - Selected `done_op` is seen through a 2-flop synchronizer.
  - On synced done = 1: `result` <= selected slice of `result_op`, `enable`<=0, counter cleared, go to LIBERA.
  - Timeout: counter reaches TIMEOUT without done → `enable`<=0, `error`<=1, `result`<=0, go to LIBERA.
- **LIBERA**
  - On synced done = 0, go to FIN.
  - Timeout here → `error`<=1, go to FIN; `result` is kept.
- **FIN**: `done`=1 for exactly one cycle, then IDLE.
- Only the selected unit's done is observed. Unselected done lines are ignored, including glitches.
- Reset asserted mid-operation returns everything to reset values immediately, including `enable`=0, without waiting for a clock edge. No `done` pulse is produced for the aborted operation.

## Timing
- Edge 0 samples `start`.
- Edge 1: `data` valid, state CARGA.
- Edge 2: `enable` high.
- Unit that raises done immediately on enable: synced done visible after edge 4; edge 5 captures result and drops enable.
- Unit drops done immediately on negedge enable: synced low after edge 7; FIN at edge 8.
- `done` is high between edges 8 and 9; `busy` falls at edge 9. Minimum latency from start sample to done: 8 cycles.
- Invalid opcode: `done` is high between edges 2 and 3.
- `busy` is high from edge 0 through the FIN cycle. A `start` in the cycle after `done` is accepted.
- Timeout count starts at 0 on entry to each wait state. Abort happens on the edge where the count equals TIMEOUT.

## Structure
- Shared package `alu_pkg`:
  - state encoding (IDLE=0, CARGA=1, ESPERA=2, LIBERA=3, FIN=4)
  - opcode constant OP_COMPLEMENTO=0
  - default widths
- Sub-module `sincronizador`: 2-flop synchronizer, async active-high reset to 0. One instance, fed by the muxed done (mux select = latched opcode).

## Test plan
- Opcode 0, A=4'hA, B=4'h3; model complemento returns ~data[7:4] zero-extended-then-inverted → `data`=8'hA3, `enable`=4'b0001 from edge 2, `result`=8'hF5, `error`=0, `done` pulse at edge 8.
- Opcode 2 with unit 2 delaying done by 6 cycles → `enable`=4'b0100 held until done synced; correct `result` slice captured; done latency 14 cycles.
- Unit never responds, TIMEOUT=15 → `enable` drops after 15 ESPERA cycles, `error`=1, `result`=0, one `done` pulse.
- `start` pulsed during ESPERA and spurious `done_op[1]` while opcode 0 active → both ignored; single completion with unit 0 result.
- `rst` asserted in ESPERA between clock edges → `enable`, `busy`, `data` go to 0 before the next edge; no `done`; next `start` runs a clean operation.
- N_OPS=3, opcode 3 → no enable ever raised, `error`=1, `done` at edge 2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, opcode constants and default widths for the ALU sequencer
package alu_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CARGA  = 3'd1,
    ESPERA = 3'd2,
    LIBERA = 3'd3,
    FIN    = 3'd4
  } estado_t;
  localparam logic [1:0] OP_COMPLEMENTO = 2'd0;
  localparam int INPUTSIZE_DEF = 8;
  localparam int N_OPS_DEF = 4;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/sincronizador.sv
// sincronizador: 2-flop synchronizer for a level crossing into the clk domain
module sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2_q, s1_q} <= 2'b00;
    else {s2_q, s1_q} <= {s1_q, d_i};
  assign q_o = s2_q;
endmodule

// File: rtl/secuenciador_alu.sv
// secuenciador_alu: drives one ALU unit per operation through an enable/done handshake and reports the result
module secuenciador_alu
  import alu_pkg::*;
#(
  parameter int INPUTSIZE = INPUTSIZE_DEF,
  parameter int N_OPS     = N_OPS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 opcode,
  input  logic [INPUTSIZE/2-1:0]     operando_a,
  input  logic [INPUTSIZE/2-1:0]     operando_b,
  output logic [INPUTSIZE-1:0]       data,
  output logic [N_OPS-1:0]           enable,
  input  logic [N_OPS-1:0]           done_op,
  input  logic [N_OPS*INPUTSIZE-1:0] result_op,
  output logic [INPUTSIZE-1:0]       result,
  output logic                       done,
  output logic                       error,
  output logic                       busy
);
  localparam int HW = INPUTSIZE / 2;
  localparam int CW = $clog2(TIMEOUT + 1);
  estado_t estado_q, estado_d;
  logic [1:0] op_q, op_d;
  logic [HW-1:0] a_q, a_d, b_q, b_d;
  logic [INPUTSIZE-1:0] data_q, data_d, result_q, result_d, sel_res;
  logic [N_OPS-1:0] enable_q, enable_d, sel_oh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, error_q, error_d, carga_q, carga_d;
  logic sel_done, done_s, expira;
  // an opcode beyond the attached units shifts out to an all-zero select
  assign sel_oh = N_OPS'(1) << op_q;
  assign sel_done = |(done_op & sel_oh);
  assign expira = cnt_q == CW'(TIMEOUT);
  always_comb begin
    sel_res = '0;
    for (int i = 0; i < N_OPS; i++) if (op_q == 2'(i)) sel_res = result_op[i*INPUTSIZE +: INPUTSIZE];
  end
  sincronizador u_sinc (
    .clk(clk),
    .rst(rst),
    .d_i(sel_done),
    .q_o(done_s)
  );
  // CARGA spans two cycles so data settles one full cycle before enable rises
  always_comb begin
    estado_d = estado_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    enable_d = enable_q;
    result_d = result_q;
    done_d = 1'b0;
    error_d = error_q;
    carga_d = 1'b0;
    cnt_d = cnt_q;
    case (estado_q)
      IDLE: if (start) begin
        op_d = opcode;
        a_d = operando_a;
        b_d = operando_b;
        error_d = 1'b0;
        estado_d = CARGA;
      end
      CARGA: begin
        data_d = {a_q, b_q};
        carga_d = !carga_q;
        if (carga_q && !(|sel_oh)) begin
          error_d = 1'b1;
          result_d = '0;
          done_d = 1'b1;
          estado_d = FIN;
        end else if (carga_q) begin
          enable_d = sel_oh;
          cnt_d = '0;
          estado_d = ESPERA;
        end
      end
      ESPERA: if (done_s) begin
        result_d = sel_res;
        enable_d = '0;
        cnt_d = '0;
        estado_d = LIBERA;
      end else if (expira) begin
        enable_d = '0;
        error_d = 1'b1;
        result_d = '0;
        cnt_d = '0;
        estado_d = LIBERA;
      end else cnt_d = cnt_q + 1'b1;
      LIBERA: if (!done_s || expira) begin
        error_d = error_q | done_s;
        done_d = 1'b1;
        estado_d = FIN;
      end else cnt_d = cnt_q + 1'b1;
      FIN: estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      estado_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      enable_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      carga_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      estado_q <= estado_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      enable_q <= enable_d;
      result_q <= result_d;
      done_q <= done_d;
      error_q <= error_d;
      carga_q <= carga_d;
      cnt_q <= cnt_d;
    end
  assign data = data_q;
  assign enable = enable_q;
  assign result = result_q;
  assign done = done_q;
  assign error = error_q;
  assign busy = estado_q != IDLE;
endmodule

// File: tb/tb_secuenciador_alu.sv
// tb_secuenciador_alu: directed checks of the sequencer against hand-computed handshake timing
module tb_secuenciador_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start3 = 1'b0;
  logic [1:0] opcode = 2'd0, opcode3 = 2'd0;
  logic [3:0] operando_a = 4'h0, operando_b = 4'h0;
  logic [7:0] data, result, data3, result3;
  logic [3:0] enable, done_op;
  logic [3:0] glitch = 4'b0000;
  logic [2:0] enable3;
  logic done, error, busy, done3, error3, busy3;
  logic [31:0] result_op;
  int dly [4] = '{0, 0, 0, 0};
  int ucnt [4] = '{0, 0, 0, 0};
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  // unit i answers dly[i] cycles after its enable rises and releases done with enable
  always @(posedge clk) for (int i = 0; i < 4; i++) ucnt[i] <= enable[i] ? ucnt[i] + 1 : 0;
  always_comb begin
    done_op = glitch;
    for (int i = 0; i < 4; i++) if (enable[i] && ucnt[i] >= dly[i]) done_op[i] = 1'b1;
  end
  assign result_op = {8'h77, data + 8'h11, 8'hEE, ~{4'h0, data[7:4]}};
  secuenciador_alu #(.INPUTSIZE(8), .N_OPS(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .operando_a(operando_a), .operando_b(operando_b), .data(data), .enable(enable),
    .done_op(done_op), .result_op(result_op), .result(result), .done(done),
    .error(error), .busy(busy)
  );
  secuenciador_alu #(.INPUTSIZE(8), .N_OPS(3), .TIMEOUT(15)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .opcode(opcode3),
    .operando_a(operando_a), .operando_b(operando_b), .data(data3), .enable(enable3),
    .done_op(3'b000), .result_op(24'h0), .result(result3), .done(done3),
    .error(error3), .busy(busy3)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    start = 1'b1;
    opcode = op;
    operando_a = a;
    operando_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic test_reset;
    tick(2);
    checks++; if ({busy, done, error, enable, data, result} !== 23'h0) begin fails++; $display("FAIL reset got=%h exp=%h", {busy, done, error, enable, data, result}, 23'h0); end
    checks++; if ({busy3, done3, error3, enable3, data3, result3} !== 22'h0) begin fails++; $display("FAIL reset3 got=%h exp=%h", {busy3, done3, error3, enable3, data3, result3}, 22'h0); end
    rst = 1'b0;
    tick(1);
  endtask
  task automatic test_complemento;
    go(2'd0, 4'hA, 4'h3);
    checks++; if ({busy, enable} !== 5'b10000) begin fails++; $display("FAIL c_edge0 got=%b exp=%b", {busy, enable}, 5'b10000); end
    tick(1);
    checks++; if ({data, enable} !== 12'hA30) begin fails++; $display("FAIL c_edge1 got=%h exp=%h", {data, enable}, 12'hA30); end
    tick(1);
    checks++; if (enable !== 4'b0001) begin fails++; $display("FAIL c_en_edge2 got=%b exp=%b", enable, 4'b0001); end
    tick(2);
    checks++; if ({done, enable} !== 5'b00001) begin fails++; $display("FAIL c_edge4 got=%b exp=%b", {done, enable}, 5'b00001); end
    tick(1);
    checks++; if ({enable, result} !== 12'h0F5) begin fails++; $display("FAIL c_edge5 got=%h exp=%h", {enable, result}, 12'h0F5); end
    tick(2);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL c_early_done got=%b exp=%b", done, 1'b0); end
    tick(1);
    checks++; if ({done, error, busy, result} !== 11'h5F5) begin fails++; $display("FAIL c_edge8 got=%h exp=%h", {done, error, busy, result}, 11'h5F5); end
    tick(1);
    checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL c_edge9 got=%b exp=%b", {done, busy}, 2'b00); end
  endtask
  task automatic test_delayed;
    dly[2] = 6;
    go(2'd2, 4'h5, 4'hC);
    tick(2);
    checks++; if ({data, enable} !== 12'h5C4) begin fails++; $display("FAIL d_edge2 got=%h exp=%h", {data, enable}, 12'h5C4); end
    tick(8);
    checks++; if (enable !== 4'b0100) begin fails++; $display("FAIL d_edge10 got=%b exp=%b", enable, 4'b0100); end
    tick(1);
    checks++; if ({enable, result} !== 12'h06D) begin fails++; $display("FAIL d_edge11 got=%h exp=%h", {enable, result}, 12'h06D); end
    tick(2);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL d_early_done got=%b exp=%b", done, 1'b0); end
    tick(1);
    checks++; if ({done, error, result} !== 10'h26D) begin fails++; $display("FAIL d_edge14 got=%h exp=%h", {done, error, result}, 10'h26D); end
    tick(1);
    dly[2] = 0;
  endtask
  task automatic test_timeout;
    dly[1] = 1000;
    go(2'd1, 4'h1, 4'h2);
    tick(17);
    checks++; if ({error, enable} !== 5'b00010) begin fails++; $display("FAIL t_edge17 got=%b exp=%b", {error, enable}, 5'b00010); end
    tick(1);
    checks++; if ({done, error, enable, result} !== 14'h1000) begin fails++; $display("FAIL t_edge18 got=%h exp=%h", {done, error, enable, result}, 14'h1000); end
    tick(1);
    checks++; if ({done, error, result} !== 10'h300) begin fails++; $display("FAIL t_edge19 got=%h exp=%h", {done, error, result}, 10'h300); end
    tick(1);
    checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL t_edge20 got=%b exp=%b", {done, busy}, 2'b00); end
    dly[1] = 0;
  endtask
  task automatic test_ignored;
    dly[0] = 4;
    go(2'd0, 4'h6, 4'h9);
    tick(3);
    start = 1'b1;
    opcode = 2'd2;
    glitch = 4'b0010;
    tick(2);
    start = 1'b0;
    glitch = 4'b0000;
    tick(1);
    checks++; if (enable !== 4'b0001) begin fails++; $display("FAIL i_edge6 got=%b exp=%b", enable, 4'b0001); end
    tick(3);
    checks++; if ({enable, result} !== 12'h0F9) begin fails++; $display("FAIL i_edge9 got=%h exp=%h", {enable, result}, 12'h0F9); end
    tick(2);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL i_early_done got=%b exp=%b", done, 1'b0); end
    tick(1);
    checks++; if ({done, error, result} !== 10'h2F9) begin fails++; $display("FAIL i_edge12 got=%h exp=%h", {done, error, result}, 10'h2F9); end
    tick(3);
    checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL i_no_queue got=%b exp=%b", {done, busy}, 2'b00); end
    dly[0] = 0;
  endtask
  task automatic test_reset_mid;
    logic seen;
    dly[0] = 1000;
    go(2'd0, 4'h7, 4'h7);
    tick(4);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, enable, data, result} !== 22'h0) begin fails++; $display("FAIL rm_async got=%h exp=%h", {busy, done, enable, data, result}, 22'h0); end
    #1 rst = 1'b0;
    @(posedge clk);
    #1 dly[0] = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= done | busy;
      tick(1);
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rm_no_done got=%b exp=%b", seen, 1'b0); end
    go(2'd0, 4'hC, 4'h0);
    tick(8);
    checks++; if ({done, error, data, result} !== 18'h2C0F3) begin fails++; $display("FAIL rm_clean got=%h exp=%h", {done, error, data, result}, 18'h2C0F3); end
    tick(1);
  endtask
  task automatic test_back_to_back;
    go(2'd0, 4'hF, 4'hF);
    tick(8);
    checks++; if ({done, result} !== 9'h1F0) begin fails++; $display("FAIL b_first got=%h exp=%h", {done, result}, 9'h1F0); end
    tick(1);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b_idle got=%b exp=%b", busy, 1'b0); end
    go(2'd3, 4'h2, 4'h4);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b_accept got=%b exp=%b", busy, 1'b1); end
    tick(2);
    checks++; if ({data, enable} !== 12'h248) begin fails++; $display("FAIL b_edge2 got=%h exp=%h", {data, enable}, 12'h248); end
    tick(6);
    checks++; if ({done, error, result} !== 10'h277) begin fails++; $display("FAIL b_second got=%h exp=%h", {done, error, result}, 10'h277); end
    tick(1);
  endtask
  task automatic test_invalid;
    start3 = 1'b1;
    opcode3 = 2'd3;
    operando_a = 4'hB;
    operando_b = 4'hD;
    @(posedge clk);
    #1 start3 = 1'b0;
    checks++; if ({busy3, done3} !== 2'b10) begin fails++; $display("FAIL v_edge0 got=%b exp=%b", {busy3, done3}, 2'b10); end
    tick(1);
    checks++; if ({done3, enable3, data3} !== 12'h0BD) begin fails++; $display("FAIL v_edge1 got=%h exp=%h", {done3, enable3, data3}, 12'h0BD); end
    tick(1);
    checks++; if ({done3, error3, busy3, enable3, result3} !== 14'h3800) begin fails++; $display("FAIL v_edge2 got=%h exp=%h", {done3, error3, busy3, enable3, result3}, 14'h3800); end
    tick(1);
    checks++; if ({done3, busy3, error3} !== 3'b001) begin fails++; $display("FAIL v_edge3 got=%b exp=%b", {done3, busy3, error3}, 3'b001); end
  endtask
  initial begin
    test_reset;
    test_complemento;
    test_delayed;
    test_timeout;
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    test_invalid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
